// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, pipelined req/gnt fetches,
// in-order response queue toward ID, and redirect flush with stale-response discard.
module if_fetch_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_jump_i,
    input  logic [XLEN-1:0] pc_jump_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW+1:0] sum_t;
    typedef logic [AW-1:0] ptr_t;

    localparam sum_t DEPTH_S = sum_t'(DEPTH);

    logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
    cnt_t            occ_q, occ_d;
    cnt_t            out_q, out_d;
    cnt_t            disc_q, disc_d;
    ptr_t            q_head_q, q_head_d;
    ptr_t            q_tail_q, q_tail_d;
    ptr_t            tag_rd_q, tag_rd_d;
    ptr_t            tag_wr_q, tag_wr_d;

    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [ILEN-1:0] q_instr_q [DEPTH];
    logic [XLEN-1:0] tag_q     [DEPTH];

    logic            grant;
    logic            resp_drop;
    logic            resp_push;
    logic            pop;
    sum_t            credit_sum;
    logic [XLEN-1:0] jump_target;
    cnt_t            grant_c;
    cnt_t            push_c;
    cnt_t            pop_c;
    cnt_t            drop_c;
    cnt_t            rvalid_c;

    // Queued, in-flight and to-be-discarded fetches all consume a credit.
    assign credit_sum = {2'b00, occ_q} + {2'b00, out_q} + {2'b00, disc_q};

    assign imem_req_o  = !rst && !is_jump_i && (credit_sum < DEPTH_S);
    assign imem_addr_o = pc_fetch_q;
    assign grant       = imem_req_o && imem_gnt_i;

    assign resp_drop = imem_rvalid_i && (disc_q != '0);
    assign resp_push = imem_rvalid_i && (disc_q == '0) && !is_jump_i && !rst;

    assign valid_o = !rst && (occ_q != '0);
    assign pop     = valid_o && ready_i && !is_jump_i;

    assign pc_o    = valid_o ? q_pc_q[q_head_q]    : '0;
    assign instr_o = valid_o ? q_instr_q[q_head_q] : '0;

    assign jump_target = pc_jump_i & ~{{(XLEN-2){1'b0}}, 2'b11};

    assign grant_c  = {{(CW-1){1'b0}}, grant};
    assign push_c   = {{(CW-1){1'b0}}, resp_push};
    assign pop_c    = {{(CW-1){1'b0}}, pop};
    assign drop_c   = {{(CW-1){1'b0}}, resp_drop};
    assign rvalid_c = {{(CW-1){1'b0}}, imem_rvalid_i};

    always_comb begin
        pc_fetch_d = pc_fetch_q;
        occ_d      = occ_q;
        out_d      = out_q;
        disc_d     = disc_q;
        q_head_d   = q_head_q;
        q_tail_d   = q_tail_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;

        if (is_jump_i) begin
            // Every fetch still in flight becomes stale; a response arriving now retires one of them.
            pc_fetch_d = jump_target;
            occ_d      = '0;
            out_d      = '0;
            disc_d     = disc_q + out_q - rvalid_c;
            q_head_d   = '0;
            q_tail_d   = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
        end else begin
            if (grant) begin
                pc_fetch_d = pc_fetch_q + {{(XLEN-3){1'b0}}, 3'd4};
                tag_wr_d   = tag_wr_q + 1'b1;
            end
            if (resp_push) begin
                tag_rd_d = tag_rd_q + 1'b1;
                q_tail_d = q_tail_q + 1'b1;
            end
            if (pop) begin
                q_head_d = q_head_q + 1'b1;
            end
            out_d  = out_q + grant_c - push_c;
            disc_d = disc_q - drop_c;
            occ_d  = occ_q + push_c - pop_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_fetch_q <= RESET_PC;
            occ_q      <= '0;
            out_q      <= '0;
            disc_q     <= '0;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            pc_fetch_q <= pc_fetch_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is live.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_q[tag_wr_q] <= pc_fetch_q;
        end
        if (resp_push) begin
            q_pc_q[q_tail_q]    <= tag_q[tag_rd_q];
            q_instr_q[q_tail_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized grant/response/ready/redirect traffic.
module tb_if_fetch_queue;

    localparam int          XLEN     = 64;
    localparam int          ILEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            is_jump_i;
    logic [XLEN-1:0] pc_jump_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [ILEN-1:0] imem_rdata_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] pc_o;
    logic [ILEN-1:0] instr_o;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst), .is_jump_i(is_jump_i), .pc_jump_i(pc_jump_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .instr_o(instr_o)
    );

    typedef struct packed { logic [63:0] addr; logic live; } req_t;
    typedef struct packed { logic [63:0] pc; logic [31:0] instr; } ent_t;

    req_t        pend[$];   // granted fetches whose response has not come back yet
    ent_t        expq[$];   // what ID must see, in order
    logic [63:0] m_pc;
    bit          m_init = 0;

    int n_cmp = 0;
    int n_bad = 0;

    bit c_gnt   = 0;
    bit c_ready = 0;
    int rv_mode = 0;    // 0 random, 1 respond whenever possible, 2 hold responses
    bit rv_force = 0;

    logic        s_valid, s_req, s_took;
    logic [63:0] s_pc, s_addr;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit j, input logic [63:0] pcj);
        bit          rv, exp_req, exp_valid, do_grant;
        logic [63:0] exp_pc;
        logic [31:0] exp_instr, rd;
        req_t        resp;
        int          csum;
        @(negedge clk);
        rst        = r;
        is_jump_i  = j;
        pc_jump_i  = pcj;
        imem_gnt_i = c_gnt;
        ready_i    = c_ready;
        rv = 0;
        if (!r && pend.size() > 0) begin
            case (rv_mode)
                0:       rv = ($urandom_range(0, 99) < 60);
                1:       rv = 1;
                default: rv = 0;
            endcase
            if (rv_force) rv = 1;
        end
        rd = $urandom;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        #1;
        exp_req   = !r && !j && (expq.size() + pend.size() < DEPTH);
        exp_valid = !r && (expq.size() > 0);
        exp_pc    = '0;
        exp_instr = '0;
        if (exp_valid) begin
            exp_pc    = expq[0].pc;
            exp_instr = expq[0].instr;
        end
        chk1("req", imem_req_o, exp_req);
        chk1("valid", valid_o, exp_valid);
        chk64("pc", pc_o, exp_pc);
        chk64("instr", {32'h0, instr_o}, {32'h0, exp_instr});
        if (!r && m_init) chk64("addr", imem_addr_o, m_pc);
        csum = int'(dut.occ_q) + int'(dut.out_q) + int'(dut.disc_q);
        chk1("credit_sum_le_depth", csum <= DEPTH, 1'b1);
        s_valid = valid_o;
        s_req   = imem_req_o;
        s_took  = imem_req_o && imem_gnt_i;
        s_pc    = pc_o;
        s_addr  = imem_addr_o;

        if (r) begin
            pend.delete();
            expq.delete();
            m_pc   = RESET_PC;
            m_init = 1;
        end else begin
            do_grant = exp_req && c_gnt;
            resp = '0;
            if (rv) resp = pend.pop_front();
            if (j) begin
                foreach (pend[k]) pend[k].live = 1'b0;
                expq.delete();
                m_pc = pcj & ~64'h3;
            end else begin
                if (c_ready && expq.size() > 0) void'(expq.pop_front());
                if (rv && resp.live) expq.push_back('{pc: resp.addr, instr: rd});
                if (do_grant) begin
                    pend.push_back('{addr: m_pc, live: 1'b1});
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    endtask

    task automatic do_reset();
        step(1, 0, '0);
        step(1, 0, '0);
    endtask

    task automatic wait_valid(input string name, input logic [63:0] exp_pc);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step(0, 0, '0);
            seen = s_valid;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, valid_o never rose (expected pc %h)", name, exp_pc);
        end else begin
            chk64(name, s_pc, exp_pc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        bit r, j;
        logic [63:0] pcj;
        rst = 1; is_jump_i = 0; pc_jump_i = '0; imem_gnt_i = 0;
        imem_rvalid_i = 0; imem_rdata_i = '0; ready_i = 0;

        // 1: streaming with single-cycle memory
        c_ready = 1; c_gnt = 1; rv_mode = 1;
        do_reset();
        chk1("t1_reset_valid", s_valid, 1'b0);
        chk1("t1_reset_req", s_req, 1'b0);
        step(0, 0, '0);
        chk1("t1_first_req", s_took, 1'b1);
        chk64("t1_first_addr", s_addr, 64'h8000_0000);
        step(0, 0, '0);
        chk1("t1_not_valid_yet", s_valid, 1'b0);
        step(0, 0, '0);
        chk1("t1_valid_2cyc", s_valid, 1'b1);
        chk64("t1_pc0", s_pc, 64'h8000_0000);
        step(0, 0, '0);
        chk64("t1_pc1", s_pc, 64'h8000_0004);
        wait_valid("t1_pc2", 64'h8000_0008);

        // 2: ID stalled, credit limit caps grants at DEPTH
        c_ready = 0;
        do_reset();
        grants = 0;
        repeat (10) begin
            step(0, 0, '0);
            if (s_took) grants++;
        end
        chk64("t2_grants", 64'(grants), 64'd2);
        chk1("t2_req_blocked", s_req, 1'b0);
        c_ready = 1;
        step(0, 0, '0);
        chk64("t2_drain0", s_pc, 64'h8000_0000);
        step(0, 0, '0);
        chk64("t2_drain1", s_pc, 64'h8000_0004);

        // 3: redirect with two requests outstanding
        rv_mode = 2;
        do_reset();
        step(0, 0, '0);
        step(0, 0, '0);
        step(0, 1, 64'h8000_1002);
        chk1("t3_no_req_flush", s_req, 1'b0);
        rv_mode = 1;
        step(0, 0, '0);
        chk64("t3_retarget", s_addr, 64'h8000_1000);
        wait_valid("t3_first_after_flush", 64'h8000_1000);

        // 4: redirect coinciding with a response, one more outstanding
        rv_mode = 2;
        do_reset();
        step(0, 0, '0);
        step(0, 0, '0);
        rv_force = 1;
        step(0, 1, 64'h8000_2000);
        rv_force = 0;
        rv_mode = 1;
        wait_valid("t4_first_after_flush", 64'h8000_2000);

        // 5: grant withheld
        c_gnt = 0;
        do_reset();
        repeat (5) begin
            step(0, 0, '0);
            chk1("t5_req_held", s_req, 1'b1);
            chk64("t5_addr_held", s_addr, 64'h8000_0000);
            chk1("t5_no_valid", s_valid, 1'b0);
        end
        c_gnt = 1;
        wait_valid("t5_resume0", 64'h8000_0000);
        step(0, 0, '0);
        chk64("t5_resume1", s_pc, 64'h8000_0004);

        // 6: PC wrap
        do_reset();
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 0, '0);
        chk64("t6_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk1("t6_granted", s_took, 1'b1);
        step(0, 0, '0);
        chk64("t6_wrap", s_addr, 64'h0);
        wait_valid("t6_first_pc", 64'hFFFF_FFFF_FFFF_FFFC);

        // randomized traffic
        rv_mode = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            c_gnt   = ($urandom_range(0, 99) < 70);
            c_ready = ($urandom_range(0, 99) < 70);
            r   = ($urandom_range(0, 999) < 3);
            j   = !r && ($urandom_range(0, 99) < 4);
            pcj = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) pcj[63:8] = '1;
            step(r, j, pcj);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
